// File: rtl/gpnae_pkg.sv
// gpnae_pkg: shared opcodes, feeder states and default widths for the activation engine feeder
package gpnae_pkg;
  localparam int DATA_WIDTH_D     = 32;
  localparam int ADDR_LINES_D     = 5;
  localparam int CONTROL_WIDTH_D  = 2;
  localparam int RESULT_DEPTH_D   = 8;
  localparam int TIMEOUT_CYCLES_D = 4096;
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_SELU    = 2'b01,
    OP_SIGMOID = 2'b10,
    OP_TANH    = 2'b11
  } op_t;
  typedef enum logic [1:0] {IDLE, LOAD, LAST, WAIT_DONE} feeder_state_t;
endpackage

// File: rtl/gpnae_result_fifo.sv
// gpnae_result_fifo: synchronous result FIFO with registered pointers and occupancy count
module gpnae_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full_o  = count == (AW+1)'(DEPTH);
  assign empty_o = count == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_ptr] <= data_i;
endmodule

// File: rtl/gpnae_feeder.sv
// gpnae_feeder: streams job terms into the activation engine and queues its results
module gpnae_feeder
  import gpnae_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int ADDR_LINES     = ADDR_LINES_D,
  parameter int CONTROL_WIDTH  = CONTROL_WIDTH_D,
  parameter int RESULT_DEPTH   = RESULT_DEPTH_D,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_D
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_LINES-1:0]    job_terms_i,
  input  logic [CONTROL_WIDTH-1:0] job_op_i,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [DATA_WIDTH-1:0]    signal_o,
  output logic                     wr_en_o,
  output logic                     last_o,
  output logic [ADDR_LINES-1:0]    terms_o,
  output logic [CONTROL_WIDTH-1:0] control_word_o,
  input  logic                     full_i,
  input  logic [DATA_WIDTH-1:0]    result_i,
  input  logic                     done_i,
  output logic [DATA_WIDTH-1:0]    res_data_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [15:0]              jobs_done_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  feeder_state_t state, state_d;
  logic [ADDR_LINES-1:0] term_cnt;
  logic [TW-1:0] to_cnt;
  logic fifo_full, fifo_empty, push, pop, hs, idle_ok, reject, accept, timeout;
  assign in_ready_o  = state == LOAD && !full_i;
  assign hs          = in_ready_o && in_valid_i;
  assign res_valid_o = !fifo_empty;
  assign pop         = res_valid_o && res_ready_i;
  assign push        = state == WAIT_DONE && done_i;
  // a full result FIFO makes start_i invisible, including illegal requests
  assign idle_ok     = state == IDLE && start_i && !fifo_full;
  assign reject      = idle_ok && (job_terms_i == '0 || job_op_i == CONTROL_WIDTH'(OP_NONE));
  assign accept      = idle_ok && !reject;
  assign timeout     = state == WAIT_DONE && !done_i && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = accept ? LOAD : IDLE;
      LOAD:      state_d = (hs && term_cnt == terms_o - ADDR_LINES'(1)) ? LAST : LOAD;
      LAST:      state_d = WAIT_DONE;
      WAIT_DONE: state_d = (push || timeout) ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      term_cnt       <= '0;
      to_cnt         <= '0;
      signal_o       <= '0;
      wr_en_o        <= 1'b0;
      last_o         <= 1'b0;
      terms_o        <= '0;
      control_word_o <= '0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
      jobs_done_o    <= '0;
    end else begin
      state    <= state_d;
      busy_o   <= state_d != IDLE;
      wr_en_o  <= hs;
      last_o   <= state == LAST;
      err_o    <= reject || timeout;
      term_cnt <= accept ? '0 : hs ? term_cnt + ADDR_LINES'(1) : term_cnt;
      to_cnt   <= state == WAIT_DONE ? to_cnt + TW'(1) : '0;
      if (hs) signal_o <= in_data_i;
      if (accept) begin
        terms_o        <= job_terms_i;
        control_word_o <= job_op_i;
      end
      if (push) jobs_done_o <= jobs_done_o + 16'd1;
    end
  end
  gpnae_result_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (RESULT_DEPTH)
  ) u_res_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (result_i),
    .pop_i  (pop),
    .data_o (res_data_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
endmodule

// File: doc/gpnae_feeder.md
Name: gpnae_feeder

Overview:
- Host-side producer for the activation engine's streaming input; it is the opposite end of the engine's signal_i/wr_en_i/last_i/done_o interface.
- Accepts a job (term count plus opcode) and a ready/valid stream of terms. Writes the terms into the engine's input FIFO, honouring full, and pulses last after the final term.
- Waits for the engine's done, captures the result into a small result FIFO, and presents it on a ready/valid output stream.

Parameters:
DATA_WIDTH, 32, width of terms and results
ADDR_LINES, 5, width of term count; must match the engine
CONTROL_WIDTH, 2, opcode width
RESULT_DEPTH, 8, result FIFO entries (power of two)
TIMEOUT_CYCLES, 4096, maximum WAIT_DONE cycles before the job is aborted

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  job request, sampled in IDLE
job_terms_i  in  ADDR_LINES  number of terms in the job
job_op_i  in  CONTROL_WIDTH  opcode: 01 SELU, 10 SIGMOID, 11 TANH
in_data_i  in  DATA_WIDTH  term data
in_valid_i  in  1  term valid
in_ready_o  out  1  term accepted when in_valid_i && in_ready_o
signal_o  out  DATA_WIDTH  term to engine
wr_en_o  out  1  engine FIFO write strobe
last_o  out  1  end-of-job pulse to engine
terms_o  out  ADDR_LINES  latched term count to engine
control_word_o  out  CONTROL_WIDTH  latched opcode to engine
full_i  in  1  engine FIFO full
result_i  in  DATA_WIDTH  engine result
done_i  in  1  engine result strobe (1-cycle pulse)
res_data_o  out  DATA_WIDTH  result head
res_valid_o  out  1  result FIFO non-empty
res_ready_i  in  1  result pop
busy_o  out  1  state != IDLE
err_o  out  1  1-cycle error pulse
jobs_done_o  out  16  completed-job counter, wraps

Behaviour:
- Interface convention: one clock, clk_i. Reset rst_i is synchronous and active-high. All outputs are registered except in_ready_o, res_valid_o and res_data_o.
- Reset clears all outputs to 0, the result FIFO to empty, the state to IDLE and all counters to 0. Reset mid-job abandons the job silently; err_o is not pulsed.
- State IDLE:
  - Job acceptance: on start_i, terms != 0, op != 00 and result FIFO not full, latch terms_o/control_word_o, clear term_cnt, go to LOAD.
  - Job rejection: if terms == 0 or op == 00, pulse err_o next cycle and stay IDLE.
  - Result FIFO full: start_i is ignored (no error) until space frees.
- State LOAD:
  - Handshake: in_ready_o = !full_i. On each handshake, next cycle drives signal_o = in_data_i and wr_en_o = 1; otherwise wr_en_o = 0.
  - full_i deasserting lets transfer resume in the same cycle.
  - On the handshake where term_cnt == terms-1, go to LAST.
- State LAST: last_o = 1 for exactly one cycle, 1 cycle after the final wr_en_o; then go to WAIT_DONE. in_ready_o = 0 in all states but LOAD.
- State WAIT_DONE:
  - Completion: on done_i, push result_i into the result FIFO, increment jobs_done_o, go to IDLE.
  - Timeout: the timeout counter counts cycles; at TIMEOUT_CYCLES, pulse err_o and go to IDLE without a push.
  - done_i outside WAIT_DONE is ignored.
- terms_o/control_word_o hold their latched values until the next accepted job; they are never changed mid-job.
- Result FIFO: registered pointers, one write and one read per cycle. Pop when res_valid_o && res_ready_i. Simultaneous push and pop at full cannot occur (a job only starts with space). Push and pop in the same cycle are both honoured.
- Minimum job latency: terms + 2 cycles to last_o, plus the engine latency.

Decomposition:
- Shared package gpnae_pkg:
  - op_t enum (OP_NONE=00, OP_SELU=01, OP_SIGMOID=10, OP_TANH=11)
  - feeder_state_t (IDLE, LOAD, LAST, WAIT_DONE)
  - default width constants
- One sub-module, gpnae_result_fifo: sync FIFO, DATA_WIDTH × RESULT_DEPTH, push/pop/full/empty.

Test Plan:
- Basic SIGMOID job: terms=4, op=10, four terms with in_valid_i held high, full_i=0 -> wr_en_o high 4 consecutive cycles, last_o one cycle later. Model done_i 10 cycles later with result_i=32'h3F000000 -> res_data_o=32'h3F000000, res_valid_o=1, jobs_done_o=1.
- Backpressure: terms=3, full_i high for 5 cycles after the first write -> exactly 3 wr_en_o pulses, none while full_i=1, data order preserved, last_o after the third.
- Illegal start: op=00 or terms=0 -> err_o pulses once, busy_o stays 0, no wr_en_o.
- Timeout: TIMEOUT_CYCLES=16, done_i never asserted -> err_o at cycle 16 of WAIT_DONE, IDLE, result FIFO empty, jobs_done_o unchanged.
- Result FIFO full: RESULT_DEPTH=2, run 2 jobs with res_ready_i=0, then start_i -> stays IDLE. Pop one -> next start accepted.
- Reset mid-LOAD: assert rst_i after 2 of 5 terms -> next cycle all outputs 0, state IDLE, no err_o.
